// File: rtl/adder_measure_sequencer.sv
// Measurement sequencer for the instrumented ripple adder: applies operands and
// ring/tap selects, times the oscillator window, samples sum and ring count.
module adder_measure_sequencer #(
    parameter int WIDTH         = 32,
    parameter int COUNT_W       = 32,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_CYCLES   = 3
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [$clog2(WIDTH)-1:0] cmd_bit,
    input  logic [15:0]              cmd_window,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic [COUNT_W-1:0]       res_count,
    output logic                     res_error,
    output logic [7:0]               res_seq,
    output logic                     busy,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic [WIDTH-1:0]         add_ring_sel,
    output logic [WIDTH-1:0]         add_tap_sel,
    output logic                     add_osc_en,
    output logic                     add_cnt_clear,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic [COUNT_W-1:0]       add_count
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {IDLE, SETUP, SETTLE, MEASURE, STOP, REPORT} state_t;

    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [15:0]   window;
    logic [BW-1:0] bit_clamped;
    logic          accept, res_take;

    assign accept   = (state == IDLE) && cmd_valid;
    assign res_take = (state == REPORT) && res_ready;

    // Only reachable for non-power-of-2 WIDTH.
    always_comb begin
        bit_clamped = cmd_bit;
        if ({1'b0, cmd_bit} > (BW+1)'(WIDTH - 1)) bit_clamped = BW'(WIDTH - 1);
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:    if (cmd_valid) state_n = SETUP;
            SETUP: begin
                state_n = SETTLE;
                cnt_n   = 16'(SETTLE_CYCLES - 1);
            end
            SETTLE:
                if (cnt == 16'd0) begin
                    state_n = MEASURE;
                    cnt_n   = (window == 16'd0) ? 16'd0 : window - 16'd1;
                end else cnt_n = cnt - 16'd1;
            MEASURE:
                if (cnt == 16'd0) begin
                    state_n = STOP;
                    cnt_n   = 16'(SYNC_CYCLES - 1);
                end else cnt_n = cnt - 16'd1;
            STOP:
                if (cnt == 16'd0) state_n = REPORT;
                else cnt_n = cnt - 16'd1;
            REPORT:  if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up
    // with the state they describe without any input-to-output path.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            window        <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            res_valid     <= 1'b0;
            res_sum       <= '0;
            res_count     <= '0;
            res_error     <= 1'b0;
            res_seq       <= '0;
            add_a         <= '0;
            add_b         <= '0;
            add_ring_sel  <= '0;
            add_tap_sel   <= '0;
            add_osc_en    <= 1'b0;
            add_cnt_clear <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            cmd_ready     <= (state_n == IDLE);
            busy          <= (state_n != IDLE);
            res_valid     <= (state_n == REPORT);
            add_osc_en    <= (state_n == MEASURE);
            add_cnt_clear <= (state_n == SETUP);
            if (accept) begin
                add_a        <= cmd_a;
                add_b        <= cmd_b;
                add_ring_sel <= ONE << bit_clamped;
                add_tap_sel  <= ONE << bit_clamped;
                window       <= cmd_window;
            end else if (res_take) begin
                add_a        <= '0;
                add_b        <= '0;
                add_ring_sel <= '0;
                add_tap_sel  <= '0;
            end
            if (state == SETTLE && cnt == 16'd0) begin
                res_sum   <= add_sum;
                res_error <= (add_sum != add_a + add_b);
            end
            if (state == STOP && cnt == 16'd0) res_count <= add_count;
            if (res_take) res_seq <= res_seq + 8'd1;
        end
    end
endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer with a result scoreboard.
module tb_adder_measure_sequencer;
    localparam int S = 4;
    localparam int Y = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [4:0]  cmd_bit = '0;
    logic [15:0] cmd_window = '0;
    logic        res_valid, res_ready = 1'b0;
    logic [31:0] res_sum, res_count;
    logic        res_error, busy;
    logic [7:0]  res_seq;
    logic [31:0] add_a, add_b, add_ring_sel, add_tap_sel;
    logic        add_osc_en, add_cnt_clear;
    logic [31:0] model_sum = '0, model_cnt = '0;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] count;
        logic        err;
        logic [7:0]  seq;
    } exp_t;
    exp_t sb[$];

    int       vecs = 0, errs = 0;
    logic [7:0] exp_seq = '0;

    always #5 clk = ~clk;

    adder_measure_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_bit(cmd_bit), .cmd_window(cmd_window),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_count(res_count), .res_error(res_error), .res_seq(res_seq),
        .busy(busy), .add_a(add_a), .add_b(add_b),
        .add_ring_sel(add_ring_sel), .add_tap_sel(add_tap_sel),
        .add_osc_en(add_osc_en), .add_cnt_clear(add_cnt_clear),
        .add_sum(model_sum), .add_count(model_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, ".res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, ".res_sum"}, 64'(res_sum), 64'd0);
        chk({tag, ".res_count"}, 64'(res_count), 64'd0);
        chk({tag, ".res_error"}, 64'(res_error), 64'd0);
        chk({tag, ".res_seq"}, 64'(res_seq), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".add_ops"}, {add_a, add_b}, 64'd0);
        chk({tag, ".add_sels"}, {add_ring_sel, add_tap_sel}, 64'd0);
        chk({tag, ".osc_clr"}, {62'd0, add_osc_en, add_cnt_clear}, 64'd0);
    endtask

    // Issue one command, follow it cycle by cycle, check timing and the
    // scoreboarded result, then optionally hold off res_ready for 'hold' cycles.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [4:0] bt,
                           input logic [15:0] win, input logic [31:0] msum,
                           input logic [31:0] mcnt, input int hold);
        int          w, lat, cyc, osc_n, first_osc, clr_n, n;
        bit          done, clr_bad, sel_bad, busy_bad, stab_bad;
        logic [31:0] sel, s;
        exp_t        e, g;
        w   = (win == 16'd0) ? 1 : int'(win);
        lat = 2 + S + w + Y;
        sel = 32'h1 << bt;
        s   = a + b;
        e.sum = msum; e.count = mcnt; e.err = (msum != s); e.seq = exp_seq;
        sb.push_back(e);
        model_sum = msum; model_cnt = mcnt;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("cmd_ready_before", 64'(cmd_ready), 64'd1);
        cmd_a = a; cmd_b = b; cmd_bit = bt; cmd_window = win; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 1; osc_n = 0; first_osc = 0; clr_n = 0;
        done = 0; clr_bad = 0; sel_bad = 0; busy_bad = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (res_valid) done = 1;
            else begin
                clr_n += int'(add_cnt_clear);
                if (add_cnt_clear && cyc != 1) clr_bad = 1;
                osc_n += int'(add_osc_en);
                if (add_osc_en && first_osc == 0) first_osc = cyc;
                if (add_ring_sel !== sel || add_tap_sel !== sel || add_a !== a || add_b !== b) sel_bad = 1;
                if (busy !== 1'b1 || cmd_ready !== 1'b0) busy_bad = 1;
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("res_latency", 64'(done ? cyc : -1), 64'(lat));
        chk("osc_cycles", 64'(osc_n), 64'(w));
        chk("osc_first", 64'(first_osc), 64'(2 + S));
        chk("clr_pulse", {31'd0, clr_bad, 32'(clr_n)}, 64'd1);
        chk("sel_hold", 64'(sel_bad), 64'd0);
        chk("busy_hold", 64'(busy_bad), 64'd0);
        chk("report_sel", {add_ring_sel, add_tap_sel}, {sel, sel});
        if (sb.size() > 0) begin
            g = sb.pop_front();
            chk("res_sum", 64'(res_sum), 64'(g.sum));
            chk("res_count", 64'(res_count), 64'(g.count));
            chk("res_error", 64'(res_error), 64'(g.err));
            chk("res_seq", 64'(res_seq), 64'(g.seq));
        end else chk("scoreboard_empty", 64'd1, 64'd0);
        stab_bad = 0;
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1; cmd_a = 32'hDEAD_0000 + 32'(h); cmd_b = 32'h55; cmd_bit = 5'd3;
            @(posedge clk); #1;
            @(negedge clk);
            if (res_valid !== 1'b1 || res_sum !== g.sum || res_count !== g.count ||
                res_error !== g.err || res_seq !== g.seq || cmd_ready !== 1'b0 ||
                add_a !== a) stab_bad = 1;
        end
        if (hold > 0) chk("backpressure_stable", 64'(stab_bad), 64'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0; cmd_valid = 1'b0;
        exp_seq = exp_seq + 8'd1;
        @(negedge clk);
        chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_busy_valid", {62'd0, busy, res_valid}, 64'd0);
        chk("post_sel_zero", {add_ring_sel, add_a}, 64'd0);
        chk("post_res_seq", 64'(res_seq), 64'(exp_seq));
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb, rs;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");

        // Basic pass
        run_cmd(32'd5, 32'd7, 5'd0, 16'd10, 32'd12, 32'd40, 0);
        // Wrapping sum: correct, then wrong
        run_cmd(32'hFFFF_FFFF, 32'd1, 5'd1, 16'd3, 32'd0, 32'd7, 0);
        run_cmd(32'hFFFF_FFFF, 32'd1, 5'd31, 16'd3, 32'd1, 32'd8, 0);
        // Selects at bit 16
        run_cmd(32'h1234, 32'h4321, 5'd16, 16'd2, 32'h5555, 32'd99, 0);
        // Window 0 acts as 1
        run_cmd(32'd100, 32'd200, 5'd4, 16'd0, 32'd300, 32'd3, 0);
        // Backpressure, then the next command straight after the release
        run_cmd(32'd9, 32'd9, 5'd8, 16'd5, 32'd18, 32'd21, 20);
        run_cmd(32'd1, 32'd2, 5'd2, 16'd1, 32'd3, 32'd4, 0);

        // Many randomised measurements walk res_seq through its wrap
        for (int i = 0; i < 256; i++) begin
            ra = $urandom; rb = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? ra + rb + 32'd1 : ra + rb;
            run_cmd(ra, rb, 5'($urandom_range(0, 31)), 16'($urandom_range(0, 6)),
                    rs, $urandom, 0);
        end

        // Reset while the oscillator is running
        model_sum = 32'd77; model_cnt = 32'd55;
        cmd_a = 32'd70; cmd_b = 32'd7; cmd_bit = 5'd5; cmd_window = 16'd10; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!add_osc_en && n < 50) begin @(posedge clk); #1; n++; end
        chk("osc_before_reset", 64'(add_osc_en), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("midreset");
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n += int'(res_valid) + int'(busy);
        end
        chk("no_result_after_reset", 64'(n), 64'd0);
        exp_seq = 8'd0;
        run_cmd(32'd70, 32'd7, 5'd5, 16'd4, 32'd77, 32'd55, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
